// File: rtl/ro_pkg.sv
// Shared types and default timing constants for the ring-oscillator sampling controller.
package ro_pkg;

    localparam int unsigned ByteWidth       = 8;
    localparam int unsigned WindowDefault   = 64;
    localparam int unsigned RecoverDefault  = 4;
    localparam int unsigned RepLimitDefault = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StCapture,
        StRecover,
        StFail
    } ro_state_e;

endpackage

// File: rtl/ro_sample_ctrl_if.sv
// Oscillator control and random-byte hand-off signals of ro_sample_ctrl.
interface ro_sample_ctrl_if;

    logic [15:0]                  ro_out;
    logic                         ro_rst;
    logic                         ro_activate;
    logic [ro_pkg::ByteWidth-1:0] rnd_data;
    logic                         rnd_valid;
    logic                         rnd_ready;
    logic                         health_fail;

    modport master (
        input  ro_out,
        input  rnd_ready,
        output ro_rst,
        output ro_activate,
        output rnd_data,
        output rnd_valid,
        output health_fail
    );

    modport slave (
        output ro_out,
        output rnd_ready,
        input  ro_rst,
        input  ro_activate,
        input  rnd_data,
        input  rnd_valid,
        input  health_fail
    );

endinterface

// File: rtl/ro_bit_sync.sv
// Two-flop synchronizer with synchronous active-high reset.
module ro_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/ro_sample_ctrl.sv
// Ring-oscillator sampling sequencer with repetition health test and byte packing.
// Define RO_VON_NEUMANN_EN to debias raw bits in pairs before packing.
module ro_sample_ctrl
    import ro_pkg::*;
#(
    parameter int unsigned WINDOW    = WindowDefault,
    parameter int unsigned RECOVER   = RecoverDefault,
    parameter int unsigned REP_LIMIT = RepLimitDefault
) (
    input logic              clk,
    input logic              rst_n,
    ro_sample_ctrl_if.master bus
);

    localparam int unsigned CntMax  = (WINDOW > RECOVER) ? WINDOW : RECOVER;
    localparam int unsigned CntW    = $clog2(CntMax);
    localparam int unsigned BitCntW = $clog2(ByteWidth);
    localparam logic [CntW-1:0]    WinLast  = CntW'(WINDOW - 1);
    localparam logic [CntW-1:0]    RecLast  = CntW'(RECOVER - 1);
    localparam logic [BitCntW-1:0] LastSlot = BitCntW'(ByteWidth - 1);

    ro_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [7:0]             rep_q, rep_d, rep_next;
    logic                   prev_q, prev_d, fail_q, fail_d;
    logic                   pend_q, pend_d, valid_q, valid_d;
    logic [ByteWidth-1:0]   pack_q, pack_d, data_q, data_d;
    logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic                   raw_bit, capture, handshake, emit, emit_bit, trip;
    logic                   ro_rst_c, ro_act_c;
    logic                   unused_ro_hi;

    assign unused_ro_hi = ^bus.ro_out[15:1];

    ro_bit_sync u_sync (
        .clk (clk),
        .rst (rst_n),
        .d   (bus.ro_out[0]),
        .q   (raw_bit)
    );

    assign capture   = (state_q == StCapture);
    assign handshake = valid_q & bus.rnd_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        ro_rst_c = 1'b1;
        ro_act_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fail_q)                    state_d = StFail;
                else if (!pend_q || handshake) state_d = StRun;
            end
            StRun: begin
                ro_rst_c = 1'b0;
                ro_act_c = 1'b1;
                if (cnt_q == WinLast) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                ro_rst_c = 1'b0;
                ro_act_c = 1'b1;
                cnt_d    = '0;
                state_d  = StRecover;
            end
            StRecover: begin
                if (cnt_q == RecLast) begin
                    cnt_d = '0;
                    if (fail_q)      state_d = StFail;
                    else if (pend_q) state_d = StIdle;
                    else             state_d = StRun;
                end
            end
            StFail: cnt_d = '0;
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Repetition count on the raw stream, saturating at 255.
    always_comb begin
        if (raw_bit != prev_q)    rep_next = 8'd1;
        else if (rep_q != 8'hFF)  rep_next = rep_q + 8'd1;
        else                      rep_next = rep_q;
    end

    assign trip = capture & (rep_next >= 8'(REP_LIMIT));

`ifdef RO_VON_NEUMANN_EN
    logic half_q, half_d, first_q;

    assign emit     = capture & half_q & (first_q != raw_bit);
    assign emit_bit = first_q;
    assign half_d   = fail_d ? 1'b0 : (capture ? ~half_q : half_q);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            half_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            half_q <= half_d;
            if (capture) first_q <= raw_bit;
        end
    end
`else
    assign emit     = capture;
    assign emit_bit = raw_bit;
`endif

    always_comb begin
        rep_d     = rep_q;
        prev_d    = prev_q;
        fail_d    = fail_q | trip;
        pend_d    = pend_q;
        valid_d   = valid_q;
        pack_d    = pack_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        if (capture) begin
            rep_d  = rep_next;
            prev_d = raw_bit;
        end
        if (handshake) valid_d = 1'b0;
        // A pending byte lives in pack until the consumer frees rnd_data.
        if (pend_q && handshake) begin
            data_d  = pack_q;
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end
        if (emit) begin
            pack_d    = {pack_q[ByteWidth-2:0], emit_bit};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastSlot) begin
                if (!valid_q || handshake) begin
                    data_d  = pack_d;
                    valid_d = 1'b1;
                end else begin
                    pend_d = 1'b1;
                end
            end
        end
        if (fail_d) begin
            valid_d   = 1'b0;
            pend_d    = 1'b0;
            pack_d    = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rep_q     <= '0;
            prev_q    <= 1'b0;
            fail_q    <= 1'b0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            pack_q    <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            prev_q    <= prev_d;
            fail_q    <= fail_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            pack_q    <= pack_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bus.ro_rst      = ro_rst_c;
    assign bus.ro_activate = ro_act_c;
    assign bus.rnd_data    = data_q;
    assign bus.rnd_valid   = valid_q;
    assign bus.health_fail = fail_q;

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// Randomized bench for ro_sample_ctrl against a bit-stream reference model.
// Honours RO_VON_NEUMANN_EN for the debiasing build.
module tb_ro_sample_ctrl;
    import ro_pkg::*;

    localparam int unsigned Win    = WindowDefault;
    localparam int unsigned Rec    = RecoverDefault;
    localparam int unsigned Lim    = RepLimitDefault;
    localparam int unsigned Period = Win + 1 + Rec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ready_fix = 1'b0;
    logic        ready_rand_en = 1'b0;
    logic        rand_bit = 1'b0;
    int unsigned cyc = 0;
    int unsigned t_run = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ro_sample_ctrl_if bus ();
    ro_sample_ctrl_if bus2 ();

    ro_sample_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ro_sample_ctrl #(
        .WINDOW  (4),
        .RECOVER (2)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign bus.rnd_ready  = ready_rand_en ? rand_bit : ready_fix;
    assign bus2.rnd_ready = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rand_bit    <= 1'($urandom);
        bus2.ro_out <= 16'($urandom);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: raw captures in, expected bytes out.
    int unsigned m_run;
    bit          m_prev;
    bit          m_fail;
    bit          m_bits[$];
    logic [7:0]  exp_q[$];
`ifdef RO_VON_NEUMANN_EN
    bit          m_half;
    bit          m_first;
`endif

    function automatic void model_reset();
        m_run  = 0;
        m_prev = 1'b0;
        m_fail = 1'b0;
        m_bits.delete();
        exp_q.delete();
`ifdef RO_VON_NEUMANN_EN
        m_half  = 1'b0;
        m_first = 1'b0;
`endif
    endfunction

    task automatic model_capture(input bit b);
        bit e;
        m_run  = (m_run != 0 && b == m_prev) ? m_run + 1 : 1;
        m_prev = b;
        if (m_run >= Lim) begin
            m_fail = 1'b1;
            m_bits.delete();
            exp_q.delete();
            return;
        end
`ifdef RO_VON_NEUMANN_EN
        if (!m_half) begin
            m_half  = 1'b1;
            m_first = b;
            return;
        end
        m_half = 1'b0;
        if (m_first == b) return;
        e = m_first;
`else
        e = b;
`endif
        m_bits.push_back(e);
        if (m_bits.size() == 8) begin
            logic [7:0] v;
            v = 8'd0;
            foreach (m_bits[i]) v[7-i] = m_bits[i];  // earliest bit ends up in the MSB
            exp_q.push_back(v);
            m_bits.delete();
        end
    endtask

    function automatic bit rand_raw();
        bit b;
        b = 1'($urandom);
        if (m_run >= 8 && b == m_prev) b = ~b;
        return b;
    endfunction

    // Handshakes happen at the next posedge with the values seen here.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            check_eq("act_vs_rst", 32'(bus.ro_activate ^ bus.ro_rst), 32'd1);
            check_eq("act2_vs_rst2", 32'(bus2.ro_activate ^ bus2.ro_rst), 32'd1);
            if (m_fail) check_eq("valid_after_fail", 32'(bus.rnd_valid), 32'd0);
            if (bus.rnd_valid && bus.rnd_ready) begin
                if (exp_q.size() == 0) check_eq("hs_unexpected", 32'(exp_q.size()), 32'd1);
                else check_eq("byte", 32'(bus.rnd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_reset(input int unsigned n);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (n) @(negedge clk);
        check_eq("rst_ro_rst", 32'(bus.ro_rst), 32'd1);
        check_eq("rst_ro_act", 32'(bus.ro_activate), 32'd0);
        check_eq("rst_valid", 32'(bus.rnd_valid), 32'd0);
        check_eq("rst_data", 32'(bus.rnd_data), 32'd0);
        check_eq("rst_health", 32'(bus.health_fail), 32'd0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("run_after_release", 32'(bus.ro_activate), 32'd1);
        t_run = cyc;
    endtask

    task automatic wait_capture(input int unsigned budget, output bit ok);
        bit prev_act;
        ok = 1'b0;
        prev_act = bus.ro_activate;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (prev_act && !bus.ro_activate) ok = 1'b1;
            prev_act = bus.ro_activate;
        end
        if (!ok) check_eq("capture_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_bit(input bit b);
        bit ok;
        bus.ro_out = {15'($urandom), b};
        wait_capture(4 * Period, ok);
        if (ok) begin
            model_capture(b);
            check_eq("health_track", 32'(bus.health_fail), 32'(m_fail));
        end
    endtask

    initial begin
        bit         pat [8];
        logic [7:0] b1, b2;
        bus.ro_out = 16'd0;

        // Reset, then abort a window mid-RUN.
        do_reset(2);
        repeat (20) @(negedge clk);
        check_eq("mid_run_act", 32'(bus.ro_activate), 32'd1);
        do_reset(3);

`ifndef RO_VON_NEUMANN_EN
        // Known byte with permanent ready.
        ready_fix = 1'b1;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        foreach (pat[i]) apply_bit(pat[i]);
        check_eq("pack_valid_rise", 32'(bus.rnd_valid), 32'd1);
        check_eq("pack_data", 32'(bus.rnd_data), 32'hB2);
        // Cycle after the 8th capture: 8 windows and captures plus 7 recoveries.
        check_eq("pack_latency", cyc - t_run, 8 * Period - Rec);
        @(negedge clk);
        check_eq("pack_valid_pulse", 32'(bus.rnd_valid), 32'd0);
`endif

        // Random raw bits with random consumer readiness.
        do_reset(1);
        ready_rand_en = 1'b1;
        repeat (40) apply_bit(rand_raw());
        ready_rand_en = 1'b0;
        ready_fix = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("random_drain", 32'(exp_q.size()), 32'd0);

        // Two bytes under backpressure.
        do_reset(1);
        ready_fix = 1'b0;
        for (int i = 0; i < 400 && exp_q.size() < 2; i++) apply_bit(rand_raw());
        check_eq("bp_two_bytes", 32'(exp_q.size()), 32'd2);
        repeat (Rec + 6) @(negedge clk);
        check_eq("bp_parked_rst", 32'(bus.ro_rst), 32'd1);
        check_eq("bp_parked_act", 32'(bus.ro_activate), 32'd0);
        b1 = exp_q[0];
        b2 = exp_q[1];
        check_eq("bp_byte1_held", 32'(bus.rnd_data), 32'(b1));
        ready_fix = 1'b1;
        @(negedge clk);
        check_eq("bp_byte2_valid", 32'(bus.rnd_valid), 32'd1);
        check_eq("bp_byte2_data", 32'(bus.rnd_data), 32'(b2));
        check_eq("bp_run_resume", 32'(bus.ro_activate), 32'd1);
        @(negedge clk);
        check_eq("bp_drained", 32'(bus.rnd_valid), 32'd0);

        // Stuck-at-one oscillator trips the repetition test.
        do_reset(1);
        ready_fix = 1'b1;
        repeat (Lim) apply_bit(1'b1);
        check_eq("hf_set", 32'(bus.health_fail), 32'd1);
        check_eq("hf_valid_low", 32'(bus.rnd_valid), 32'd0);
        repeat (2 * Period) @(negedge clk);
        check_eq("hf_sticky", 32'(bus.health_fail), 32'd1);
        check_eq("hf_fail_rst", 32'(bus.ro_rst), 32'd1);
        check_eq("hf_fail_act", 32'(bus.ro_activate), 32'd0);
        do_reset(2);

        // Short-window instance: 5 running cycles then 2 in reset.
        for (int i = 0; i < 70; i++) begin
            check_eq("wave_ro_rst", 32'(bus2.ro_rst), ((i % 7) >= 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

`ifdef RO_VON_NEUMANN_EN
        do_reset(1);
        pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        foreach (pat[i]) apply_bit(pat[i]);
        apply_bit(1'b1);
        apply_bit(1'b0);
        check_eq("vn_model_count", 32'(m_bits.size()), 32'd3);
        check_eq("vn_count", 32'(dut.bit_cnt_q), 32'(m_bits.size()));
        check_eq("vn_health", 32'(bus.health_fail), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1, "simulation time budget exhausted");
    end

endmodule
